// File: rtl/tsn_ptp_pkg.sv
// Shared PTP constants, FSM encoding and timestamp helpers for the TSN timestamp units.
// Pure definitions: no latency, no flow control.
package tsn_ptp_pkg;

   localparam logic [15:0] ETHERTYPE_PTP     = 16'h88F7;
   localparam logic [15:0] ETHERTYPE_VLAN    = 16'h8100;
   localparam logic [10:0] PTP_ORIGIN_TS_OFF = 11'd34;
   localparam logic [3:0]  PTP_TS_LEN        = 4'd10;
   localparam logic [31:0] NS_PER_SEC        = 32'd1_000_000_000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ETH,
      ST_VLAN,
      ST_PTP,
      ST_WAIT,
      ST_INS,
      ST_PASS
   } tsi_state_t;

   typedef struct packed {
      logic [47:0] sec;
      logic [31:0] ns;
   } ptp_ts_t;

   // Byte idx of the on-wire originTimestamp: seconds MSB first, then nanoseconds.
   function automatic logic [7:0] ts_byte(input ptp_ts_t ts, input logic [3:0] idx);
      logic [7:0] b;
      case (idx)
         4'd0:    b = ts.sec[47:40];
         4'd1:    b = ts.sec[39:32];
         4'd2:    b = ts.sec[31:24];
         4'd3:    b = ts.sec[23:16];
         4'd4:    b = ts.sec[15:8];
         4'd5:    b = ts.sec[7:0];
         4'd6:    b = ts.ns[31:24];
         4'd7:    b = ts.ns[23:16];
         4'd8:    b = ts.ns[15:8];
         4'd9:    b = ts.ns[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/ptp_ts_adjust.sv
// Adds a fixed ns offset to a PTP timestamp, folding ns overflow into seconds.
// Latency 1 cycle (registered); no flow control, output tracks input every cycle.
module ptp_ts_adjust
   import tsn_ptp_pkg::*;
#(
   parameter logic [31:0] OFFSET_NS = 32'd0
)(
   input  logic    mac_axis_aclk,
   input  logic    rst,
   input  ptp_ts_t ts_in,
   output ptp_ts_t ts_out
);

   logic [32:0] ns_sum;

   assign ns_sum = {1'b0, ts_in.ns} + {1'b0, OFFSET_NS};

   always_ff @(posedge mac_axis_aclk or posedge rst) begin
      if (rst) begin
         ts_out <= '0;
      end else if (ns_sum >= {1'b0, NS_PER_SEC}) begin
         ts_out.sec <= ts_in.sec + 48'd1;
         ts_out.ns  <= 32'(ns_sum - {1'b0, NS_PER_SEC});
      end else begin
         ts_out.sec <= ts_in.sec;
         ts_out.ns  <= ns_sum[31:0];
      end
   end

endmodule

// File: rtl/tsi_axis.sv
// One-step TX PTP inserter: overwrites originTimestamp of enabled L2 PTP event frames.
// Latency 1 cycle, 1 byte/cycle; s_axis_tready = !m_axis_tvalid || m_axis_tready, stalls freeze all state.
module tsi_axis
   import tsn_ptp_pkg::*;
#(
   parameter logic [31:0] EGRESS_OFFSET_NS = 32'd0,
   parameter int          CNT_W            = 16
)(
   input  logic             rst,
   input  logic             mac_axis_aclk,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   input  logic [7:0]       s_axis_tdata,
   input  logic             s_axis_tlast,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic [7:0]       m_axis_tdata,
   output logic             m_axis_tlast,
   input  logic             ins_en,
   input  logic [7:0]       ptp_msgid_mask,
   input  logic [79:0]      rtc_timer_in,
   output logic             ins_pulse,
   output logic [CNT_W-1:0] ins_count
);

   tsi_state_t  state;
   logic [10:0] bcnt;
   logic [10:0] base;
   logic [7:0]  et_hi;
   logic [7:0]  mask_f;
   logic        en_f;
   logic [3:0]  sidx;
   ptp_ts_t     ts_raw;
   ptp_ts_t     ts_adj;
   logic        acc;
   logic [3:0]  msg_type;
   logic [7:0]  out_byte;

   assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
   assign acc           = s_axis_tvalid && s_axis_tready;
   assign msg_type      = s_axis_tdata[3:0];
   assign out_byte      = (state == ST_INS) ? ts_byte(ts_adj, sidx) : s_axis_tdata;

   ptp_ts_adjust #(
      .OFFSET_NS (EGRESS_OFFSET_NS)
   ) u_ts_adjust (
      .mac_axis_aclk (mac_axis_aclk),
      .rst           (rst),
      .ts_in         (ts_raw),
      .ts_out        (ts_adj)
   );

   always_ff @(posedge mac_axis_aclk or posedge rst) begin
      if (rst) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= 8'h00;
         m_axis_tlast  <= 1'b0;
      end else if (acc) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= out_byte;
         m_axis_tlast  <= s_axis_tlast;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   always_ff @(posedge mac_axis_aclk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         bcnt      <= 11'd0;
         base      <= 11'd0;
         et_hi     <= 8'h00;
         mask_f    <= 8'h00;
         en_f      <= 1'b0;
         sidx      <= 4'd0;
         ts_raw    <= '0;
         ins_pulse <= 1'b0;
         ins_count <= '0;
      end else begin
         ins_pulse <= 1'b0;
         if (acc) begin
            if (s_axis_tlast)
               bcnt <= 11'd0;
            else if (bcnt != 11'h7FF)
               bcnt <= bcnt + 11'd1;

            // Last field byte counts even when it also ends the frame.
            if (state == ST_INS && sidx == PTP_TS_LEN - 4'd1) begin
               ins_pulse <= 1'b1;
               ins_count <= ins_count + CNT_W'(1);
            end

            if (state == ST_IDLE) begin
               ts_raw <= rtc_timer_in;
               en_f   <= ins_en;
               mask_f <= ptp_msgid_mask;
            end

            if (bcnt == 11'd12 || bcnt == 11'd16)
               et_hi <= s_axis_tdata;

            if (s_axis_tlast) begin
               state <= ST_IDLE;
            end else begin
               case (state)
                  ST_IDLE: state <= ST_ETH;
                  ST_ETH: begin
                     if (bcnt == 11'd13) begin
                        if ({et_hi, s_axis_tdata} == ETHERTYPE_PTP) begin
                           state <= ST_PTP;
                           base  <= 11'd14;
                        end else if ({et_hi, s_axis_tdata} == ETHERTYPE_VLAN) begin
                           state <= ST_VLAN;
                        end else begin
                           state <= ST_PASS;
                        end
                     end
                  end
                  ST_VLAN: begin
                     if (bcnt == 11'd17) begin
                        if ({et_hi, s_axis_tdata} == ETHERTYPE_PTP) begin
                           state <= ST_PTP;
                           base  <= 11'd18;
                        end else begin
                           state <= ST_PASS;
                        end
                     end
                  end
                  ST_PTP: begin
                     if (bcnt == base)
                        state <= (en_f && !msg_type[3] && mask_f[msg_type[2:0]]) ? ST_WAIT : ST_PASS;
                  end
                  ST_WAIT: begin
                     if (bcnt == base + PTP_ORIGIN_TS_OFF - 11'd1) begin
                        state <= ST_INS;
                        sidx  <= 4'd0;
                     end
                  end
                  ST_INS: begin
                     sidx <= sidx + 4'd1;
                     if (sidx == PTP_TS_LEN - 4'd1)
                        state <= ST_PASS;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_tsi_axis.sv
// Scoreboard bench for tsi_axis: expected frames are queued as stimulus is built,
// output beats are captured on the falling edge and compared per scenario task.
`timescale 1ns/1ps
module tb_tsi_axis;

   localparam logic [31:0] OFFSET = 32'd10;

   logic        rst;
   logic        mac_axis_aclk;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tlast;
   logic        ins_en;
   logic [7:0]  ptp_msgid_mask;
   logic [79:0] rtc_timer_in;
   logic        ins_pulse;
   logic [15:0] ins_count;

   tsi_axis #(
      .EGRESS_OFFSET_NS (OFFSET),
      .CNT_W            (16)
   ) dut (
      .rst            (rst),
      .mac_axis_aclk  (mac_axis_aclk),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tlast   (s_axis_tlast),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tlast   (m_axis_tlast),
      .ins_en         (ins_en),
      .ptp_msgid_mask (ptp_msgid_mask),
      .rtc_timer_in   (rtc_timer_in),
      .ins_pulse      (ins_pulse),
      .ins_count      (ins_count)
   );

   initial mac_axis_aclk = 1'b0;
   always #5 mac_axis_aclk = ~mac_axis_aclk;

   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   int          pulses = 0;
   bit          stall_en = 1'b0;
   logic [7:0]  frame[$];
   logic [7:0]  exp_q[$];
   logic [8:0]  got_q[$];
   int          got_cyc[$];
   logic [15:0] exp_count = 16'd0;

   always @(negedge mac_axis_aclk) begin
      cyc++;
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         got_q.push_back({m_axis_tlast, m_axis_tdata});
         got_cyc.push_back(cyc);
      end
      if (ins_pulse) pulses++;
   end

   initial begin
      forever begin
         @(posedge mac_axis_aclk);
         #1;
         m_axis_tready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   task automatic build_frame(input bit vlan, input logic [15:0] etype, input logic [7:0] msg, input int len);
      frame.delete();
      for (int i = 0; i < len; i++) frame.push_back(8'(i * 37 + 11));
      if (vlan) begin
         frame[12] = 8'h81; frame[13] = 8'h00;
         frame[16] = etype[15:8]; frame[17] = etype[7:0]; frame[18] = msg;
      end else begin
         frame[12] = etype[15:8]; frame[13] = etype[7:0]; frame[14] = msg;
      end
   endtask

   // Reference: ns + offset, fold into seconds at 1e9, overwrite field bytes present in the frame.
   task automatic make_expected(input bit ins, input int base, input logic [47:0] sec, input logic [31:0] ns);
      longint      t;
      logic [79:0] v;
      t = longint'(ns) + longint'(OFFSET);
      if (t >= 64'd1000000000) begin
         t   = t - 64'd1000000000;
         sec = sec + 48'd1;
      end
      v = {sec, 32'(t)};
      exp_q.delete();
      for (int i = 0; i < frame.size(); i++) begin
         if (ins && i >= base + 34 && i < base + 44) exp_q.push_back(v[79 - 8 * (i - base - 34) -: 8]);
         else exp_q.push_back(frame[i]);
      end
   endtask

   // Drives the frame; after SOP it scrambles rtc/enable/mask to show they were latched.
   task automatic drive_frame(input int rst_at, output bit ok);
      bit a;
      int t;
      ok = 1'b1;
      for (int i = 0; i < frame.size(); i++) begin
         if (i == rst_at) begin
            rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
            return;
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = frame[i];
         s_axis_tlast  = (i == frame.size() - 1);
         t = 0;
         do begin
            @(negedge mac_axis_aclk);
            a = s_axis_tready;
            @(posedge mac_axis_aclk);
            #1;
            t++;
         end while (!a && t < 1000);
         if (!a) begin
            ok = 1'b0;
            s_axis_tvalid = 1'b0;
            return;
         end
         if (i == 0) begin
            rtc_timer_in   = ~rtc_timer_in;
            ins_en         = ~ins_en;
            ptp_msgid_mask = ~ptp_msgid_mask;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      t = 0;
      while (got_q.size() < frame.size() && t < 2000) begin
         @(posedge mac_axis_aclk);
         #1;
         t++;
      end
      if (got_q.size() < frame.size()) ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge mac_axis_aclk);
      #1;
      checks++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, ins_pulse} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 000", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, ins_pulse});
      end
      checks++;
      if (ins_count !== 16'd0) begin
         errors++; $display("FAIL reset_count got %0d want 0", ins_count);
      end
      checks++;
      if (s_axis_tready !== 1'b1) begin
         errors++; $display("FAIL reset_tready got %b want 1", s_axis_tready);
      end
      rst = 1'b0;
      @(posedge mac_axis_aclk);
      #1;
   endtask

   task automatic test_insert();
      bit          vl[6]  = '{0, 1, 0, 1, 0, 1};
      logic [7:0]  msg[6] = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h03};
      logic [7:0]  mk[6]  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h08};
      logic [47:0] sc[6]  = '{48'd1, 48'd1, 48'd7, 48'hFFFF_FFFF_FFFF, 48'h1234_5678, 48'd42};
      logic [31:0] nc[6]  = '{32'd5, 32'd5, 32'd999_999_995, 32'd999_999_990, 32'd999_999_989, 32'd123_456_789};
      bit          st[6]  = '{0, 0, 0, 0, 1, 1};
      logic [8:0]  e, g;
      int          n, p0;
      bit          ok;
      for (int c = 0; c < 6; c++) begin
         build_frame(vl[c], 16'h88F7, msg[c], 64);
         make_expected(1'b1, vl[c] ? 18 : 14, sc[c], nc[c]);
         ins_en = 1'b1; ptp_msgid_mask = mk[c]; rtc_timer_in = {sc[c], nc[c]};
         stall_en = st[c];
         p0 = pulses; got_q.delete(); got_cyc.delete();
         drive_frame(-1, ok);
         exp_count++;
         checks++;
         if (ok !== 1'b1) begin errors++; $display("FAIL ins_timeout case=%0d got %b want 1", c, ok); end
         n = exp_q.size();
         checks++;
         if (got_q.size() !== n) begin errors++; $display("FAIL ins_beats case=%0d got %0d want %0d", c, got_q.size(), n); end
         for (int i = 0; i < n; i++) begin
            e = {(i == n - 1), exp_q.pop_front()};
            g = (got_q.size() > 0) ? got_q.pop_front() : 9'bx;
            checks++;
            if (g !== e) begin errors++; $display("FAIL ins_byte case=%0d idx=%0d got %h want %h", c, i, g, e); end
         end
         checks++;
         if (ins_count !== exp_count) begin errors++; $display("FAIL ins_count case=%0d got %0d want %0d", c, ins_count, exp_count); end
         checks++;
         if (pulses - p0 !== 1) begin errors++; $display("FAIL ins_pulse case=%0d got %0d want 1", c, pulses - p0); end
         if (!st[c] && got_cyc.size() == 64) begin
            checks++;
            if (got_cyc[63] - got_cyc[0] !== 63) begin
               errors++; $display("FAIL no_bubble case=%0d got %0d want 63", c, got_cyc[63] - got_cyc[0]);
            end
         end
      end
      stall_en = 1'b0;
      repeat (2) begin @(posedge mac_axis_aclk); #1; end
   endtask

   task automatic test_passthrough();
      bit          vl[5]  = '{0, 0, 0, 1, 1};
      logic [15:0] et[5]  = '{16'h88F7, 16'h0800, 16'h88F7, 16'h88F7, 16'h0800};
      logic [7:0]  msg[5] = '{8'h01, 8'h00, 8'h00, 8'h09, 8'h00};
      logic [7:0]  mk[5]  = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      bit          en[5]  = '{1, 1, 0, 1, 1};
      logic [8:0]  e, g;
      int          n, p0;
      bit          ok;
      for (int c = 0; c < 5; c++) begin
         build_frame(vl[c], et[c], msg[c], 64);
         make_expected(1'b0, 14, 48'd3, 32'd3);
         ins_en = en[c]; ptp_msgid_mask = mk[c]; rtc_timer_in = {48'd9, 32'd9};
         p0 = pulses; got_q.delete();
         drive_frame(-1, ok);
         checks++;
         if (ok !== 1'b1) begin errors++; $display("FAIL pass_timeout case=%0d got %b want 1", c, ok); end
         n = exp_q.size();
         for (int i = 0; i < n; i++) begin
            e = {(i == n - 1), exp_q.pop_front()};
            g = (got_q.size() > 0) ? got_q.pop_front() : 9'bx;
            checks++;
            if (g !== e) begin errors++; $display("FAIL pass_byte case=%0d idx=%0d got %h want %h", c, i, g, e); end
         end
         checks++;
         if (ins_count !== exp_count) begin errors++; $display("FAIL pass_count case=%0d got %0d want %0d", c, ins_count, exp_count); end
         checks++;
         if (pulses !== p0) begin errors++; $display("FAIL pass_pulse case=%0d got %0d want 0", c, pulses - p0); end
      end
   endtask

   task automatic test_short_frame();
      int          len[2] = '{52, 58};
      logic [8:0]  e, g;
      int          n, p0;
      bit          ok;
      for (int c = 0; c < 2; c++) begin
         build_frame(1'b0, 16'h88F7, 8'h00, len[c]);
         make_expected(1'b1, 14, 48'hABCD, 32'd777);
         ins_en = 1'b1; ptp_msgid_mask = 8'h01; rtc_timer_in = {48'hABCD, 32'd777};
         p0 = pulses; got_q.delete();
         drive_frame(-1, ok);
         if (len[c] == 58) exp_count++;
         checks++;
         if (ok !== 1'b1) begin errors++; $display("FAIL short_timeout len=%0d got %b want 1", len[c], ok); end
         n = exp_q.size();
         for (int i = 0; i < n; i++) begin
            e = {(i == n - 1), exp_q.pop_front()};
            g = (got_q.size() > 0) ? got_q.pop_front() : 9'bx;
            checks++;
            if (g !== e) begin errors++; $display("FAIL short_byte len=%0d idx=%0d got %h want %h", len[c], i, g, e); end
         end
         checks++;
         if (ins_count !== exp_count) begin errors++; $display("FAIL short_count len=%0d got %0d want %0d", len[c], ins_count, exp_count); end
         checks++;
         if (pulses - p0 !== (len[c] == 58 ? 1 : 0)) begin
            errors++; $display("FAIL short_pulse len=%0d got %0d want %0d", len[c], pulses - p0, (len[c] == 58 ? 1 : 0));
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [8:0]  e, g;
      int          n, p0;
      bit          ok;
      build_frame(1'b0, 16'h88F7, 8'h00, 64);
      ins_en = 1'b1; ptp_msgid_mask = 8'h01; rtc_timer_in = {48'd2, 32'd100};
      got_q.delete();
      drive_frame(30, ok);
      #1;
      checks++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, ins_pulse} !== 11'd0) begin
         errors++;
         $display("FAIL midrst_outputs got %h want 000", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, ins_pulse});
      end
      checks++;
      if (ins_count !== 16'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", ins_count); end
      @(posedge mac_axis_aclk);
      #1;
      rst = 1'b0;
      exp_count = 16'd0;
      @(posedge mac_axis_aclk);
      #1;
      build_frame(1'b1, 16'h88F7, 8'h00, 64);
      make_expected(1'b1, 18, 48'h55AA, 32'd999_999_999);
      ins_en = 1'b1; ptp_msgid_mask = 8'h01; rtc_timer_in = {48'h55AA, 32'd999_999_999};
      p0 = pulses; got_q.delete();
      drive_frame(-1, ok);
      exp_count++;
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL midrst_timeout got %b want 1", ok); end
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = {(i == n - 1), exp_q.pop_front()};
         g = (got_q.size() > 0) ? got_q.pop_front() : 9'bx;
         checks++;
         if (g !== e) begin errors++; $display("FAIL midrst_byte idx=%0d got %h want %h", i, g, e); end
      end
      checks++;
      if (ins_count !== exp_count) begin errors++; $display("FAIL midrst_after_count got %0d want %0d", ins_count, exp_count); end
      checks++;
      if (pulses - p0 !== 1) begin errors++; $display("FAIL midrst_pulse got %0d want 1", pulses - p0); end
   endtask

   initial begin
      rst            = 1'b1;
      s_axis_tvalid  = 1'b0;
      s_axis_tdata   = 8'h00;
      s_axis_tlast   = 1'b0;
      m_axis_tready  = 1'b1;
      ins_en         = 1'b0;
      ptp_msgid_mask = 8'h00;
      rtc_timer_in   = 80'd0;
      test_reset();
      test_insert();
      test_passthrough();
      test_short_frame();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
